// File: rtl/sqrt_seq_ctrl_pkg.sv
// rtl/sqrt_seq_ctrl_pkg.sv - states, ALU opcodes, register map and control word for sqrt_seq_ctrl
package sqrt_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LDA  = 4'd1,
    S_LDB  = 4'd2,
    S_ABSA = 4'd3,
    S_ABSB = 4'd4,
    S_MAXS = 4'd5,
    S_MINS = 4'd6,
    S_SH3  = 4'd7,
    S_SUBS = 4'd8,
    S_SH1  = 4'd9,
    S_ADDS = 4'd10,
    S_MAXF = 4'd11,
    S_OUT  = 4'd12,
    S_DONE = 4'd13
  } state_e;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ABS  = 3'd1;
  localparam logic [2:0] OP_MAX  = 3'd2;
  localparam logic [2:0] OP_MIN  = 3'd3;
  localparam logic [2:0] OP_SHR1 = 3'd4;
  localparam logic [2:0] OP_SHR3 = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_SUB  = 3'd7;

  localparam logic [2:0] A_REG = 3'd0;
  localparam logic [2:0] B_REG = 3'd1;
  localparam logic [2:0] X_REG = 3'd2;
  localparam logic [2:0] Y_REG = 3'd3;
  localparam logic [2:0] T_REG = 3'd4;
  localparam logic [2:0] U_REG = 3'd5;
  localparam logic [2:0] R_REG = 3'd6;

  // Addresses are kept 3 bits wide here; the top zero-extends to ADDR_W.
  typedef struct packed {
    logic       in_ready;
    logic       out_valid;
    logic       in_sel;
    logic       rf_we;
    logic [2:0] waddr;
    logic [2:0] raddr_a;
    logic [2:0] raddr_b;
    logic [2:0] alu_op;
    logic       out_en;
    logic       busy;
    logic       done;
  } ctrl_word_t;

endpackage

// File: rtl/sqrt_seq_ctrl_if.sv
// rtl/sqrt_seq_ctrl_if.sv - batch start/done, operand/result handshakes and datapath control pins
interface sqrt_seq_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
);
  logic              start;
  logic [CNT_W-1:0]  n_pairs;
  logic              in_valid;
  logic              in_ready;
  logic              out_ready;
  logic              out_valid;
  logic              in_sel;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [ADDR_W-1:0] rf_raddr_a;
  logic [ADDR_W-1:0] rf_raddr_b;
  logic [2:0]        alu_op;
  logic              out_en;
  logic              busy;
  logic              done;
  logic [3:0]        state;
  logic [15:0]       perf_cycles;

  modport master (
    input  start, n_pairs, in_valid, out_ready,
    output in_ready, out_valid, in_sel, rf_we, rf_waddr, rf_raddr_a, rf_raddr_b,
           alu_op, out_en, busy, done, state, perf_cycles
  );

  modport slave (
    output start, n_pairs, in_valid, out_ready,
    input  in_ready, out_valid, in_sel, rf_we, rf_waddr, rf_raddr_a, rf_raddr_b,
           alu_op, out_en, busy, done, state, perf_cycles
  );
endinterface

// File: rtl/sqrt_seq_ctrl_decode.sv
// rtl/sqrt_seq_ctrl_decode.sv - combinational state to datapath control-word decoder
module sqrt_seq_decode
  import sqrt_seq_pkg::*;
(
  input  state_e     state_i,
  output ctrl_word_t cw_o
);

  always_comb begin
    cw_o      = '0;
    cw_o.busy = (state_i != S_IDLE);
    case (state_i)
      S_LDA: begin
        cw_o.in_ready = 1'b1;
        cw_o.rf_we    = 1'b1;
        cw_o.in_sel   = 1'b1;
        cw_o.waddr    = A_REG;
      end
      S_LDB: begin
        cw_o.in_ready = 1'b1;
        cw_o.rf_we    = 1'b1;
        cw_o.in_sel   = 1'b1;
        cw_o.waddr    = B_REG;
      end
      S_ABSA: begin
        cw_o.rf_we   = 1'b1;
        cw_o.raddr_a = A_REG;
        cw_o.alu_op  = OP_ABS;
        cw_o.waddr   = A_REG;
      end
      S_ABSB: begin
        cw_o.rf_we   = 1'b1;
        cw_o.raddr_a = B_REG;
        cw_o.alu_op  = OP_ABS;
        cw_o.waddr   = B_REG;
      end
      S_MAXS: begin
        cw_o.rf_we   = 1'b1;
        cw_o.raddr_a = A_REG;
        cw_o.raddr_b = B_REG;
        cw_o.alu_op  = OP_MAX;
        cw_o.waddr   = X_REG;
      end
      S_MINS: begin
        cw_o.rf_we   = 1'b1;
        cw_o.raddr_a = A_REG;
        cw_o.raddr_b = B_REG;
        cw_o.alu_op  = OP_MIN;
        cw_o.waddr   = Y_REG;
      end
      S_SH3: begin
        cw_o.rf_we   = 1'b1;
        cw_o.raddr_a = X_REG;
        cw_o.alu_op  = OP_SHR3;
        cw_o.waddr   = T_REG;
      end
      S_SUBS: begin
        cw_o.rf_we   = 1'b1;
        cw_o.raddr_a = X_REG;
        cw_o.raddr_b = T_REG;
        cw_o.alu_op  = OP_SUB;
        cw_o.waddr   = T_REG;
      end
      S_SH1: begin
        cw_o.rf_we   = 1'b1;
        cw_o.raddr_a = Y_REG;
        cw_o.alu_op  = OP_SHR1;
        cw_o.waddr   = U_REG;
      end
      S_ADDS: begin
        cw_o.rf_we   = 1'b1;
        cw_o.raddr_a = T_REG;
        cw_o.raddr_b = U_REG;
        cw_o.alu_op  = OP_ADD;
        cw_o.waddr   = R_REG;
      end
      S_MAXF: begin
        cw_o.rf_we   = 1'b1;
        cw_o.raddr_a = R_REG;
        cw_o.raddr_b = X_REG;
        cw_o.alu_op  = OP_MAX;
        cw_o.waddr   = R_REG;
      end
      S_OUT: begin
        cw_o.raddr_a   = R_REG;
        cw_o.out_en    = 1'b1;
        cw_o.out_valid = 1'b1;
      end
      S_DONE: cw_o.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/sqrt_seq_ctrl.sv
// rtl/sqrt_seq_ctrl.sv - batch FSM sequencing the sqrt(a^2+b^2) approximation datapath
// Busy-cycle counter on perf_cycles is built only with SQRT_SEQ_CTRL_PERF_EN defined.
module sqrt_seq_ctrl
  import sqrt_seq_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
)(
  input  logic           clk,
  input  logic           rst_n,
  sqrt_seq_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] npairs_q, npairs_d;
  ctrl_word_t       cw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      npairs_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      npairs_q <= npairs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    npairs_d = npairs_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          npairs_d = (bus.n_pairs == '0) ? CNT_W'(1) : bus.n_pairs;
          cnt_d    = '0;
          state_d  = S_LDA;
        end
      end
      S_LDA:  if (bus.in_valid) state_d = S_LDB;
      S_LDB:  if (bus.in_valid) state_d = S_ABSA;
      S_ABSA: state_d = S_ABSB;
      S_ABSB: state_d = S_MAXS;
      S_MAXS: state_d = S_MINS;
      S_MINS: state_d = S_SH3;
      S_SH3:  state_d = S_SUBS;
      S_SUBS: state_d = S_SH1;
      S_SH1:  state_d = S_ADDS;
      S_ADDS: state_d = S_MAXF;
      S_MAXF: state_d = S_OUT;
      S_OUT: begin
        // Latched count is at least 1, so count-1 never underflows.
        if (bus.out_ready) begin
          if (cnt_q == npairs_q - CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_LDA;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  sqrt_seq_decode u_decode (
    .state_i (state_q),
    .cw_o    (cw)
  );

  assign bus.in_ready   = cw.in_ready;
  assign bus.out_valid  = cw.out_valid;
  assign bus.in_sel     = cw.in_sel;
  assign bus.rf_we      = cw.rf_we;
  assign bus.rf_waddr   = ADDR_W'(cw.waddr);
  assign bus.rf_raddr_a = ADDR_W'(cw.raddr_a);
  assign bus.rf_raddr_b = ADDR_W'(cw.raddr_b);
  assign bus.alu_op     = cw.alu_op;
  assign bus.out_en     = cw.out_en;
  assign bus.busy       = cw.busy;
  assign bus.done       = cw.done;
  assign bus.state      = state_q;

`ifdef SQRT_SEQ_CTRL_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Value survives IDLE so software can read it after done.
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (bus.start) perf_d = '0;
    end else if (perf_q != 16'hFFFF) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// tb/tb_sqrt_seq_ctrl.sv - scoreboard bench for sqrt_seq_ctrl with a behavioural datapath
module tb_sqrt_seq_ctrl;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sqrt_seq_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
  sqrt_seq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic signed [15:0] in_data;
  logic signed [15:0] rf [0:7];
  logic signed [15:0] out_bus;

  function automatic logic signed [15:0] alu(input logic [2:0] op, input logic signed [15:0] a,
                                             input logic signed [15:0] b);
    case (op)
      3'd1:    return (a < 0) ? -a : a;
      3'd2:    return (a > b) ? a : b;
      3'd3:    return (a < b) ? a : b;
      3'd4:    return a >>> 1;
      3'd5:    return a >>> 3;
      3'd6:    return a + b;
      3'd7:    return a - b;
      default: return a;
    endcase
  endfunction

  always @(posedge clk)
    if (bus.rf_we)
      rf[bus.rf_waddr] <= bus.in_sel ? in_data : alu(bus.alu_op, rf[bus.rf_raddr_a], rf[bus.rf_raddr_b]);
  assign out_bus = bus.out_en ? rf[bus.rf_raddr_a] : 'x;

  function automatic int ref_sqrt(input int a, input int b);
    int x, y, r;
    x = (a < 0) ? -a : a;
    y = (b < 0) ? -b : b;
    if (y > x) begin r = x; x = y; y = r; end
    r = x - x / 8 + y / 2;
    return (r > x) ? r : x;
  endfunction

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int t0 = 0;
  int done_cnt = 0, done_cyc = 0, busy_cnt = 0, inr_cnt = 0;
  int exp_q[$];
  int opa[$], opb[$];
  logic [63:0] prev_cw, cw_now;
  bit prev_stall = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting, expected event within bound", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops, stall stability and event counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      cw_now = {42'd0, bus.in_ready, bus.out_valid, bus.in_sel, bus.rf_we, bus.rf_waddr,
                bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op, bus.out_en, bus.busy, bus.state};
      if (prev_stall) check("stall_hold", cw_now, prev_cw);
      prev_stall = (bus.in_ready && !bus.in_valid) || (bus.out_valid && !bus.out_ready);
      prev_cw = cw_now;
      if (bus.done) begin
        done_cnt++;
        done_cyc = edge_cnt - t0 + 1;
      end
      if (bus.busy) busy_cnt++;
      if (bus.in_ready) inr_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL out_unexpected: got result %0d, expected no output", out_bus);
        end else begin
          check("result", out_bus, exp_q.pop_front());
        end
      end
`ifndef SQRT_SEQ_CTRL_PERF_EN
      check("perf_zero", bus.perf_cycles, 0);
`endif
    end
  end

  task automatic add_pair(input int a, input int b);
    opa.push_back(a);
    opb.push_back(b);
  endtask

  task automatic run_batch(input int n_cfg, input int in_st, input int out_st, input bit poke);
    int n_eff, guard, d0, exp_done;
    n_eff = (n_cfg == 0) ? 1 : n_cfg;
    exp_done = 12 * n_eff + 1 + n_eff * (in_st + out_st);
    guard = 0;
    while (bus.busy && guard < 400) begin tick(); guard++; end
    bus.start = 1'b1;
    bus.n_pairs = CNT_W'(n_cfg);
    tick();
    bus.start = 1'b0;
    t0 = edge_cnt;
    bus.n_pairs = CNT_W'($urandom);
    d0 = done_cnt;
    busy_cnt = 0;
    inr_cnt = 0;
    for (int p = 0; p < n_eff; p++) begin
      bus.in_valid = 1'b0;
      in_data = 16'($urandom);
      guard = 0;
      while (!bus.in_ready && guard < 60) begin tick(); guard++; end
      if (!bus.in_ready) timeout("in_ready");
      repeat (in_st) begin in_data = 16'($urandom); tick(); end
      bus.in_valid = 1'b1;
      in_data = 16'(opa[p]);
      tick();
      in_data = 16'(opb[p]);
      tick();
      bus.in_valid = 1'b0;
      in_data = 16'($urandom);
      exp_q.push_back(ref_sqrt(opa[p], opb[p]));
      if (poke && p == 0) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
      end
      bus.out_ready = (out_st == 0);
      guard = 0;
      while (!bus.out_valid && guard < 60) begin tick(); guard++; end
      if (!bus.out_valid) timeout("out_valid");
      repeat (out_st) tick();
      bus.out_ready = 1'b1;
      tick();
    end
    tick();
    check("done_pulses", done_cnt - d0, 1);
    check("done_cycle", done_cyc, exp_done);
    check("busy_cycles", busy_cnt, exp_done);
    check("in_ready_cycles", inr_cnt, 2 * n_eff + n_eff * in_st);
    check("busy_after", bus.busy, 0);
    check("state_after", bus.state, 0);
`ifdef SQRT_SEQ_CTRL_PERF_EN
    check("perf_cycles", bus.perf_cycles, exp_done);
`else
    check("perf_cycles", bus.perf_cycles, 0);
`endif
    if (poke) begin
      repeat (3) tick();
      check("poke_single_done", done_cnt - d0, 1);
      check("poke_idle", bus.busy, 0);
    end
    opa.delete();
    opb.delete();
  endtask

  function automatic logic [63:0] all_outs();
    return {24'd0, bus.in_ready, bus.out_valid, bus.in_sel, bus.rf_we, bus.rf_waddr,
            bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op, bus.out_en, bus.busy, bus.done,
            bus.state, bus.perf_cycles};
  endfunction

  task automatic reset_in_subs();
    int guard;
    bus.start = 1'b1;
    bus.n_pairs = CNT_W'(1);
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    in_data = 16'sd3;
    tick();
    in_data = -16'sd4;
    tick();
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.state != 4'd8 && guard < 40) begin tick(); guard++; end
    if (bus.state != 4'd8) timeout("reach_subs");
    rst_n = 1'b0;
    #2;
    check("rst_async_outs", all_outs(), 0);
    tick();
    check("rst_held_outs", all_outs(), 0);
    rst_n = 1'b1;
    tick();
    check("rst_release_state", bus.state, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.n_pairs = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    tick();
    check("idle_outs", all_outs(), 0);

    add_pair(3, -4);
    run_batch(1, 0, 0, 1'b0);
    add_pair(3, -4); add_pair(0, 0); add_pair(-8, 6);
    run_batch(3, 0, 0, 1'b0);
    add_pair(3, -4);
    run_batch(1, 4, 3, 1'b0);
    add_pair(-7, 12);
    run_batch(0, 0, 0, 1'b1);
    add_pair(100, -250); add_pair(-33, 77);
    run_batch(2, 0, 0, 1'b0);
    reset_in_subs();
    add_pair(3, -4);
    run_batch(1, 0, 0, 1'b0);
    for (int p = 0; p < 15; p++) add_pair($urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000);
    run_batch(15, 0, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      int n, ist, ost;
      n = $urandom_range(1, 4);
      ist = $urandom_range(0, 3);
      ost = $urandom_range(0, 3);
      for (int p = 0; p < n; p++) add_pair($urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000);
      run_batch(n, ist, ost, 1'b0);
    end
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
